// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcodes, ALU function codes,
// sequencer states and the control word carried to the datapath.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;
  localparam logic [9:0] OP_EORI = 10'b1101001000;

  localparam logic [7:0] OP_CBZ  = 8'b10110100;
  localparam logic [7:0] OP_CBNZ = 8'b10110101;
  localparam logic [5:0] OP_B    = 6'b000101;

  // {function[2:0], invert_b, carry_in}
  localparam logic [4:0] FS_AND    = 5'b00000;
  localparam logic [4:0] FS_ORR    = 5'b00100;
  localparam logic [4:0] FS_ADD    = 5'b01000;
  localparam logic [4:0] FS_SUB    = 5'b01011;
  localparam logic [4:0] FS_EOR    = 5'b01100;
  localparam logic [4:0] FS_LSL    = 5'b10000;
  localparam logic [4:0] FS_LSR    = 5'b10100;
  localparam logic [4:0] FS_PASS_B = 5'b11000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEMRD, S_WB, S_PCUPD, S_HALT
  } state_t;

  typedef struct packed {
    logic [4:0]  DA;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  FS;
    logic        dataMux;
    logic        regW;
    logic        ramW;
    logic        Bsel;
    logic [63:0] k;
  } cw_t;

  function automatic cw_t mk_cw(
    input logic [4:0]  da,
    input logic [4:0]  sa,
    input logic [4:0]  sb,
    input logic [4:0]  fs,
    input logic        bsel,
    input logic [63:0] kv
  );
    cw_t c;
    c      = '0;
    c.DA   = da;
    c.SA   = sa;
    c.SB   = sb;
    c.FS   = fs;
    c.Bsel = bsel;
    c.k    = kv;
    return c;
  endfunction

endpackage

// File: rtl/legv8_control_unit_if.sv
// Instruction-memory fetch port: req held until a one-cycle ack
// strobe returns the instruction word.
interface legv8_control_unit_if;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_addr, imem_req,
    input  imem_ack, imem_data
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_ack, imem_data
  );
endinterface

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 decoder: instruction word to control word,
// instruction-class flags and PC-relative branch offset.
module legv8_decoder
  import legv8_pkg::*;
(
  input  logic [31:0] ir,
  output cw_t         cw,
  output logic        is_ldur,
  output logic        is_stur,
  output logic        is_branch,
  output logic        is_cbz,
  output logic        is_cbnz,
  output logic        illegal,
  output logic [63:0] branch_offset
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;
  logic [63:0] shamt_z, imm12_z, dt9_s, b_off, cb_off;

  assign op11    = ir[31:21];
  assign op10    = ir[31:22];
  assign op8     = ir[31:24];
  assign op6     = ir[31:26];
  assign rd      = ir[4:0];
  assign rn      = ir[9:5];
  assign rm      = ir[20:16];
  assign shamt_z = {58'd0, ir[15:10]};
  assign imm12_z = {52'd0, ir[21:10]};
  assign dt9_s   = {{55{ir[20]}}, ir[20:12]};
  assign b_off   = {{36{ir[25]}}, ir[25:0], 2'b00};
  assign cb_off  = {{43{ir[23]}}, ir[23:5], 2'b00};

  // Opcode spaces are disjoint, so the longest-first order never
  // has two arms true at once.
  always_comb begin
    cw            = '0;
    is_ldur       = 1'b0;
    is_stur       = 1'b0;
    is_branch     = 1'b0;
    is_cbz        = 1'b0;
    is_cbnz       = 1'b0;
    illegal       = 1'b0;
    branch_offset = '0;
    unique case (1'b1)
      op11 == OP_ADD: cw = mk_cw(rd, rn, rm, FS_ADD, 1'b1, 64'd0);
      op11 == OP_SUB: cw = mk_cw(rd, rn, rm, FS_SUB, 1'b1, 64'd0);
      op11 == OP_AND: cw = mk_cw(rd, rn, rm, FS_AND, 1'b1, 64'd0);
      op11 == OP_ORR: cw = mk_cw(rd, rn, rm, FS_ORR, 1'b1, 64'd0);
      op11 == OP_EOR: cw = mk_cw(rd, rn, rm, FS_EOR, 1'b1, 64'd0);
      op11 == OP_LSL: cw = mk_cw(rd, rn, rm, FS_LSL, 1'b0, shamt_z);
      op11 == OP_LSR: cw = mk_cw(rd, rn, rm, FS_LSR, 1'b0, shamt_z);
      op11 == OP_LDUR: begin
        cw      = mk_cw(rd, rn, 5'd0, FS_ADD, 1'b0, dt9_s);
        is_ldur = 1'b1;
      end
      op11 == OP_STUR: begin
        cw      = mk_cw(5'd0, rn, rd, FS_ADD, 1'b0, dt9_s);
        is_stur = 1'b1;
      end
      op10 == OP_ADDI: cw = mk_cw(rd, rn, 5'd0, FS_ADD, 1'b0, imm12_z);
      op10 == OP_SUBI: cw = mk_cw(rd, rn, 5'd0, FS_SUB, 1'b0, imm12_z);
      op10 == OP_ANDI: cw = mk_cw(rd, rn, 5'd0, FS_AND, 1'b0, imm12_z);
      op10 == OP_ORRI: cw = mk_cw(rd, rn, 5'd0, FS_ORR, 1'b0, imm12_z);
      op10 == OP_EORI: cw = mk_cw(rd, rn, 5'd0, FS_EOR, 1'b0, imm12_z);
      op8 == OP_CBZ: begin
        cw            = mk_cw(5'd0, 5'd0, rd, FS_PASS_B, 1'b1, 64'd0);
        is_cbz        = 1'b1;
        branch_offset = cb_off;
      end
      op8 == OP_CBNZ: begin
        cw            = mk_cw(5'd0, 5'd0, rd, FS_PASS_B, 1'b1, 64'd0);
        is_cbnz       = 1'b1;
        branch_offset = cb_off;
      end
      op6 == OP_B: begin
        cw            = mk_cw(5'd0, 5'd0, 5'd0, FS_AND, 1'b0, b_off);
        is_branch     = 1'b1;
        branch_offset = b_off;
      end
      default: illegal = 1'b1;
    endcase
    cw.regW    = ~(is_ldur | is_stur | is_branch
                 | is_cbz | is_cbnz | illegal);
    cw.ramW    = is_stur;
    cw.dataMux = is_ldur;
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer: owns the PC, fetches over imem,
// and drives the registered control word into the datapath.
module legv8_control_unit
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  legv8_control_unit_if.master        imem,
  input  logic [3:0]                  status,
  output logic [4:0]                  DA,
  output logic [4:0]                  SA,
  output logic [4:0]                  SB,
  output logic [4:0]                  FS,
  output logic                        dataMux,
  output logic                        regW,
  output logic                        ramW,
  output logic                        R,
  output logic                        Bsel,
  output logic [63:0]                 k,
  output logic                        halted
);

  state_t      state_q, state_d;
  logic [63:0] pc_q;
  logic [31:0] ir_q;
  cw_t         cw_q, dec_cw;
  logic        taken_q, taken, r_q;
  logic        is_ldur, is_stur, is_branch;
  logic        is_cbz, is_cbnz, illegal;
  logic [63:0] br_off;
  logic        unused_bits;

  legv8_decoder u_dec (
    .ir            (ir_q),
    .cw            (dec_cw),
    .is_ldur       (is_ldur),
    .is_stur       (is_stur),
    .is_branch     (is_branch),
    .is_cbz        (is_cbz),
    .is_cbnz       (is_cbnz),
    .illegal       (illegal),
    .branch_offset (br_off)
  );

  assign taken = is_branch
               | (is_cbz & status[0])
               | (is_cbnz & ~status[0]);

  assign unused_bits = ^{status[3:1], is_stur};

  always_comb begin
    state_d = state_q;
    regW    = 1'b0;
    ramW    = 1'b0;
    dataMux = 1'b0;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (imem.imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
      S_EXEC: begin
        regW    = cw_q.regW;
        ramW    = cw_q.ramW;
        state_d = is_ldur ? S_MEMRD : S_PCUPD;
      end
      S_MEMRD:  state_d = S_WB;
      S_WB: begin
        regW    = 1'b1;
        dataMux = cw_q.dataMux;
        state_d = S_PCUPD;
      end
      S_PCUPD:  state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // r_q holds the datapath in reset for the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cw_q    <= '0;
      taken_q <= 1'b0;
      r_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= 1'b0;
      if (state_q == S_FETCH && imem.imem_ack)
        ir_q <= imem.imem_data;
      if (state_q == S_DECODE)
        cw_q <= dec_cw;
      if (state_q == S_EXEC)
        taken_q <= taken;
      if (state_q == S_PCUPD)
        pc_q <= taken_q ? pc_q + br_off : pc_q + 64'd4;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign DA             = cw_q.DA;
  assign SA             = cw_q.SA;
  assign SB             = cw_q.SB;
  assign FS             = cw_q.FS;
  assign Bsel           = cw_q.Bsel;
  assign k              = cw_q.k;
  assign R              = r_q;
  assign halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench: an instruction-level model predicts fetch
// addresses and register/RAM write pulses; a monitor checks them.
module tb_legv8_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run   = 1'b0;
  logic [3:0]  status = 4'd0;
  logic [4:0]  DA, SA, SB, FS;
  logic        dataMux, regW, ramW, R, Bsel, halted;
  logic [63:0] k;

  legv8_control_unit_if imem();

  legv8_control_unit #(.RESET_PC(64'h0)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .imem    (imem),
    .status  (status),
    .DA      (DA),
    .SA      (SA),
    .SB      (SB),
    .FS      (FS),
    .dataMux (dataMux),
    .regW    (regW),
    .ramW    (ramW),
    .R       (R),
    .Bsel    (Bsel),
    .k       (k),
    .halted  (halted)
  );

  always #5 clock = ~clock;

  localparam int K_R = 0, K_SH = 1, K_I = 2, K_LDUR = 3;
  localparam int K_STUR = 4, K_B = 5, K_CB = 6;

  localparam logic [10:0] R_OPC [5] = '{11'b10001011000, 11'b11001011000,
    11'b10001010000, 11'b10101010000, 11'b11001010000};
  localparam logic [9:0] I_OPC [5] = '{10'b1001000100, 10'b1101000100,
    10'b1001001000, 10'b1011001000, 10'b1101001000};
  // ADD, SUB, AND, ORR, EOR as {function, invert_b, carry_in}
  localparam logic [4:0] OP_FS [5] = '{5'b01000, 5'b01011,
    5'b00000, 5'b00100, 5'b01100};
  localparam logic [10:0] SH_OPC [2] = '{11'b11010011011, 11'b11010011010};
  localparam logic [4:0]  SH_FS [2]  = '{5'b10000, 5'b10100};

  typedef struct packed {
    logic        reg_w;
    logic        ram_w;
    logic        dmux;
    logic        bsel;
    logic        chk_da;
    logic        chk_sb;
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  fs;
    logic [63:0] kv;
  } wr_t;

  wr_t         exp_wr[$];
  logic [63:0] exp_fetch[$];
  logic [63:0] pc;
  int          checks = 0;
  int          errors = 0;

  initial begin : monitor
    logic        prev_req;
    logic [63:0] a;
    wr_t         e;
    bit          ok;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_req = 1'b0;
      end else begin
        if (imem.imem_req && !prev_req) begin
          checks++;
          if (exp_fetch.size() == 0) begin
            errors++;
            $display("FAIL fetch_unexpected addr=%h", imem.imem_addr);
          end else begin
            a = exp_fetch.pop_front();
            if (imem.imem_addr !== a) begin
              errors++;
              $display("FAIL fetch_addr got=%h exp=%h", imem.imem_addr, a);
            end
          end
        end
        prev_req = imem.imem_req;
        if (regW || ramW) begin
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected regW=%b ramW=%b", regW, ramW);
          end else begin
            e  = exp_wr.pop_front();
            ok = (regW === e.reg_w) && (ramW === e.ram_w)
              && (dataMux === e.dmux) && (SA === e.sa)
              && (FS === e.fs) && (Bsel === e.bsel)
              && (!e.chk_da || DA === e.da)
              && (!e.chk_sb || SB === e.sb)
              && (e.bsel || k === e.kv);
            if (!ok) begin
              errors++;
              $display("FAIL write_word got regW=%b ramW=%b dmux=%b DA=%0d SA=%0d SB=%0d FS=%b Bsel=%b k=%h exp regW=%b ramW=%b dmux=%b DA=%0d SA=%0d SB=%0d FS=%b Bsel=%b k=%h",
                regW, ramW, dataMux, DA, SA, SB, FS, Bsel, k,
                e.reg_w, e.ram_w, e.dmux, e.da, e.sa, e.sb, e.fs, e.bsel, e.kv);
            end
          end
        end
      end
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (imem.imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic issue(input logic [31:0] w, input int dly,
                       input logic [3:0] st);
    bit ok;
    wait_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fetch_timeout got=0 exp=1");
      return;
    end
    repeat (dly) @(negedge clock);
    status         = st;
    imem.imem_data = w;
    imem.imem_ack  = 1'b1;
    @(negedge clock);
    imem.imem_ack  = 1'b0;
    if ($urandom_range(0, 1) == 1) begin
      imem.imem_data = 32'h0;
      imem.imem_ack  = 1'b1;
      @(negedge clock);
      imem.imem_ack  = 1'b0;
    end
  endtask

  task automatic do_instr(input int kind, input int sub,
                          input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [25:0] imm,
                          input int dly, input logic [3:0] st);
    logic [31:0] w;
    logic [63:0] nxt;
    wr_t         e;
    bit          has_wr;
    bit          tk;
    e      = '0;
    has_wr = 1'b1;
    nxt    = pc + 64'd4;
    w      = 32'h0;
    case (kind)
      K_R: begin
        w = {R_OPC[sub], rm, imm[5:0], rn, rd};
        e.reg_w = 1'b1; e.da = rd; e.sa = rn; e.sb = rm;
        e.chk_da = 1'b1; e.chk_sb = 1'b1;
        e.fs = OP_FS[sub]; e.bsel = 1'b1;
      end
      K_SH: begin
        w = {SH_OPC[sub % 2], rm, imm[5:0], rn, rd};
        e.reg_w = 1'b1; e.da = rd; e.sa = rn; e.chk_da = 1'b1;
        e.fs = SH_FS[sub % 2]; e.kv = {58'd0, imm[5:0]};
      end
      K_I: begin
        w = {I_OPC[sub], imm[11:0], rn, rd};
        e.reg_w = 1'b1; e.da = rd; e.sa = rn; e.chk_da = 1'b1;
        e.fs = OP_FS[sub]; e.kv = {52'd0, imm[11:0]};
      end
      K_LDUR: begin
        w = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        e.reg_w = 1'b1; e.dmux = 1'b1; e.da = rd; e.sa = rn;
        e.chk_da = 1'b1; e.fs = 5'b01000;
        e.kv = {{55{imm[8]}}, imm[8:0]};
      end
      K_STUR: begin
        w = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        e.ram_w = 1'b1; e.sa = rn; e.sb = rd; e.chk_sb = 1'b1;
        e.fs = 5'b01000; e.kv = {{55{imm[8]}}, imm[8:0]};
      end
      K_B: begin
        w = {6'b000101, imm};
        has_wr = 1'b0;
        nxt = pc + {{36{imm[25]}}, imm, 2'b00};
      end
      default: begin
        w = {((sub % 2) == 1) ? 8'hB5 : 8'hB4, imm[18:0], rd};
        has_wr = 1'b0;
        tk = ((sub % 2) == 1) ? (st[0] == 1'b0) : (st[0] == 1'b1);
        if (tk) nxt = pc + {{43{imm[18]}}, imm[18:0], 2'b00};
      end
    endcase
    if (has_wr) exp_wr.push_back(e);
    exp_fetch.push_back(nxt);
    pc = nxt;
    issue(w, dly, st);
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin : main
    bit ok;
    imem.imem_ack  = 1'b0;
    imem.imem_data = 32'h0;
    pc = 64'h0;

    repeat (3) @(negedge clock);
    chk("reset_R", {63'd0, R}, 64'd1);
    chk("reset_req_halt", {62'd0, imem.imem_req, halted}, 64'd0);
    chk("reset_word", {DA, SA, SB, FS, dataMux, regW, ramW, Bsel},
        64'd0);
    chk("reset_k", k, 64'd0);

    exp_fetch.push_back(64'h0);
    reset = 1'b1;
    run   = 1'b1;
    #1;
    chk("R_after_release", {63'd0, R}, 64'd1);
    @(negedge clock);
    chk("R_after_edge", {63'd0, R}, 64'd0);

    do_instr(K_I, 0, 5'd1, 5'd0, 5'd0, 26'd5, 2, 4'd0);
    do_instr(K_LDUR, 0, 5'd2, 5'd1, 5'd0, 26'h1F8, 0, 4'd0);
    do_instr(K_STUR, 0, 5'd2, 5'd1, 5'd0, 26'd0, 1, 4'd0);
    do_instr(K_R, 0, 5'd4, 5'd2, 5'd3, 26'd0, 0, 4'd0);
    do_instr(K_CB, 0, 5'd3, 5'd0, 5'd0, 26'd3, 0, 4'b0001);
    do_instr(K_CB, 0, 5'd3, 5'd0, 5'd0, 26'd3, 0, 4'b1110);
    do_instr(K_CB, 1, 5'd3, 5'd0, 5'd0, 26'd3, 0, 4'b0001);
    do_instr(K_CB, 1, 5'd3, 5'd0, 5'd0, 26'd3, 0, 4'b0000);
    do_instr(K_I, 0, 5'd31, 5'd31, 5'd0, 26'hFFF, 0, 4'd0);

    for (int n = 0; n < 40; n++) begin
      do_instr($urandom_range(0, 6), $urandom_range(0, 4),
               5'($urandom), 5'($urandom), 5'($urandom),
               26'($urandom), $urandom_range(0, 3),
               4'($urandom));
    end

    issue(32'h0000_0000, 1, 4'd0);
    repeat (12) @(negedge clock);
    chk("halted_set", {63'd0, halted}, 64'd1);
    chk("halt_no_req", {63'd0, imem.imem_req}, 64'd0);

    reset = 1'b0;
    #1;
    chk("reset_clears_halt", {63'd0, halted}, 64'd0);
    @(negedge clock);
    exp_fetch.push_back(64'h0);
    reset = 1'b1;
    wait_req(ok);
    chk("refetch_seen", {63'd0, ok}, 64'd1);

    @(posedge clock);
    #2;
    reset          = 1'b0;
    imem.imem_data = 32'h9100_1401;
    imem.imem_ack  = 1'b1;
    #1;
    chk("midfetch_req_drop", {63'd0, imem.imem_req}, 64'd0);
    chk("midfetch_pc", imem.imem_addr, 64'h0);
    @(negedge clock);
    @(negedge clock);
    imem.imem_ack = 1'b0;
    run           = 1'b0;
    reset         = 1'b1;
    repeat (6) @(negedge clock);
    chk("idle_after_reset", {62'd0, imem.imem_req, regW}, 64'd0);
    chk("queues_drained", 64'(exp_fetch.size() + exp_wr.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
